axi_burst_addr_gen: RTL and testbench
=====================================

# axi_burst_addr_gen

Per-beat address generator for AXI AW/AR commands inside the crossbar. It accepts one address-channel command (id, addr, len, size, burst) and emits one beat descriptor per data beat. Each descriptor carries the address, beat index, last flag and an error flag. It covers FIXED, INCR and WRAP bursts, and write-data routing and read-response slicing both use it. It is parametrised in address, ID and data width. Burst/len/size field widths come from the shared AXI package.

## Interface
- AddrWidth, 32, address width in bits
- IdWidth, 4, transaction ID width
- DataWidth, 64, data bus width in bits (power of two, 8..1024); MaxSize = log2(DataWidth/8)
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- ax_valid_i  in  1  command valid
- ax_ready_o  out  1  command ready
- ax_id_i  in  IdWidth  command ID
- ax_addr_i  in  AddrWidth  start address
- ax_len_i  in  LenWidth  beats minus one
- ax_size_i  in  SizeWidth  log2 bytes per beat
- ax_burst_i  in  BurstWidth  burst type
- beat_valid_o  out  1  beat descriptor valid
- beat_ready_i  in  1  beat descriptor accepted
- beat_id_o  out  IdWidth  ID of the owning command
- beat_addr_o  out  AddrWidth  address of this beat
- beat_idx_o  out  LenWidth  beat number, 0..len
- beat_last_o  out  1  final beat of the burst
- beat_err_o  out  1  command illegal; held for every beat of that burst
- busy_o  out  1  burst in progress

## Operation
- FSM with two states.
  - IDLE: ax_ready_o=1. On ax_valid_i&ax_ready_o, latch the command, set idx=0 and go to BURST.
  - BURST: beat_valid_o=1. On beat_valid_o&beat_ready_i, idx increments and the address advances. On the last beat, go to IDLE, or stay in BURST if a new command is accepted in the same cycle.
- ax_ready_o = IDLE | (beat_valid_o & beat_ready_i & beat_last_o). Back-to-back bursts have no bubble.
- bytes = 1<<size. aligned = addr with its low size bits cleared.
- FIXED: every beat uses the start address.
- INCR: beat 0 uses the start address, which may be unaligned. Beat i>0 uses aligned + i*bytes.
- WRAP:
  - total = bytes*(len+1); lower = addr rounded down to a multiple of total.
  - next = addr+bytes. If next == lower+total, next = lower.
- Arithmetic is done at AddrWidth bits, modulo 2^AddrWidth. Overflow wraps silently.
- Error conditions; any of them sets beat_err_o=1 on every beat of that burst:
  - burst==2'b11 (reserved);
  - size>MaxSize;
  - WRAP with len not in {1,3,7,15};
  - WRAP with an unaligned start address.
- An errored burst still produces len+1 beats. Addresses follow the INCR rule, with size clamped to MaxSize.
- beat_last_o = (idx==len). len=0 gives a single beat with last=1.

## Timing
- Reset:
  - state IDLE, ax_ready_o=1, busy_o=0;
  - beat_valid_o=0, beat_last_o=0, beat_err_o=0;
  - beat_id_o/beat_addr_o/beat_idx_o=0.
- Latency: a command accepted at cycle N gives its first beat valid at N+1. All beat outputs are registered.
- When beat_valid_o=1 and beat_ready_i=0, all beat_* outputs hold stable.
- Throughput is one beat per cycle while beat_ready_i=1.
- ax_ready_o is combinational from beat_ready_i and registered state. No other input→output combinational path exists.
- Reset asserted mid-burst abandons the burst. On the next cycle the block is in reset state; no partial beats follow.
- busy_o = state==BURST.

## Configuration
- AXI_BURST_4K_CHECK_EN defined:
  - an INCR burst whose last byte lies in a different 4 KiB page than its first byte sets beat_err_o on all its beats;
  - FIXED and WRAP bursts are unaffected.
- Not defined: the check logic is absent and 4K crossing is never flagged. The port list is unchanged.

## Structure
- axi_pkg gains the following, all BurstWidth-wide or typed on existing widths:
  - BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10;
  - typedefs burst_t, len_t, size_t;
  - function beat_bytes(size_t).
- One sub-module, axi_burst_next_addr: combinational next-address computation (FIXED/INCR/WRAP, clamp). The FSM and registers stay in the top module.

## Test plan
- INCR, addr=0x1003, len=3, size=2 → addrs 0x1003, 0x1004, 0x1008, 0x100C; idx 0..3; last on idx 3; err=0.
- WRAP, addr=0x0038, len=3, size=3 → addrs 0x38, 0x20, 0x28, 0x30; last on the 4th beat.
- FIXED, addr=0x40, len=2, with beat_ready_i low 2 cycles on beat 1 → three beats of 0x40; outputs stable while stalled.
- Two INCR len=0 commands back-to-back with beat_ready_i=1 → ax_ready_o high on the last beat; the second beat is valid the very next cycle.
- burst=2'b11, then WRAP with len=2 → all beats err=1 and INCR addresses. With AXI_BURST_4K_CHECK_EN: INCR addr=0xFF8, len=1, size=3 → err=1; the same burst at 0xFF0 → err=0.
- rst_ni low at idx 2 of a len=7 burst → next cycle beat_valid_o=0, ax_ready_o=1, busy_o=0.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI field widths, burst encodings and the burst FSM state type.
package axi_pkg;

  localparam int unsigned BurstWidth = 2;
  localparam int unsigned LenWidth   = 8;
  localparam int unsigned SizeWidth  = 3;

  typedef logic [BurstWidth-1:0] burst_t;
  typedef logic [LenWidth-1:0]   len_t;
  typedef logic [SizeWidth-1:0]  size_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

  typedef enum logic {
    BURST_IDLE,
    BURST_ACTIVE
  } burst_state_e;

  function automatic logic [7:0] beat_bytes(input size_t size);
    return 8'(1) << size;
  endfunction

endpackage

// File: rtl/axi_burst_next_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; errored bursts
// step as INCR with the beat size clamped to the bus width.
module axi_burst_next_addr
  import axi_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned MaxSize   = 3
) (
  input  logic [AddrWidth-1:0]  cur_addr_i,
  input  logic [BurstWidth-1:0] burst_i,
  input  logic [SizeWidth-1:0]  size_i,
  input  logic [LenWidth-1:0]   len_i,
  input  logic                  err_i,
  output logic [AddrWidth-1:0]  next_addr_o
);

  size_t                size_eff;
  logic [AddrWidth-1:0] bytes;
  logic [AddrWidth-1:0] total;
  logic [AddrWidth-1:0] incr_addr;

  always_comb begin
    size_eff = size_i;
    if (err_i && (size_i > SizeWidth'(MaxSize))) size_eff = SizeWidth'(MaxSize);
    bytes     = AddrWidth'(beat_bytes(size_eff));
    total     = bytes * (AddrWidth'(len_i) + AddrWidth'(1));
    incr_addr = (cur_addr_i & ~(bytes - AddrWidth'(1))) + bytes;

    next_addr_o = incr_addr;
    if (!err_i) begin
      unique case (burst_i)
        BURST_FIXED: next_addr_o = cur_addr_i;
        BURST_INCR:  next_addr_o = incr_addr;
        // total is a power of two here, so wrapping is a masked increment
        BURST_WRAP:  next_addr_o = (cur_addr_i & ~(total - AddrWidth'(1)))
                                 | ((cur_addr_i + bytes) & (total - AddrWidth'(1)));
        default:     next_addr_o = incr_addr;
      endcase
    end
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address generator for AXI AW/AR commands.
// Optional AXI_BURST_4K_CHECK_EN flags INCR bursts that cross a 4 KiB page.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DataWidth = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ax_valid_i,
  output logic                  ax_ready_o,
  input  logic [IdWidth-1:0]    ax_id_i,
  input  logic [AddrWidth-1:0]  ax_addr_i,
  input  logic [LenWidth-1:0]   ax_len_i,
  input  logic [SizeWidth-1:0]  ax_size_i,
  input  logic [BurstWidth-1:0] ax_burst_i,
  output logic                  beat_valid_o,
  input  logic                  beat_ready_i,
  output logic [IdWidth-1:0]    beat_id_o,
  output logic [AddrWidth-1:0]  beat_addr_o,
  output logic [LenWidth-1:0]   beat_idx_o,
  output logic                  beat_last_o,
  output logic                  beat_err_o,
  output logic                  busy_o
);

  localparam int unsigned MaxSize = $clog2(DataWidth / 8);

  burst_state_e         state_q;
  burst_t               burst_q;
  size_t                size_q;
  len_t                 len_q;
  logic [AddrWidth-1:0] next_addr;
  logic [AddrWidth-1:0] bytes_in;
  logic                 cmd_err;
  logic                 ax_hs;
  logic                 beat_hs;
`ifdef AXI_BURST_4K_CHECK_EN
  logic [AddrWidth-1:0] last_byte;
`endif

  assign beat_hs    = beat_valid_o & beat_ready_i;
  assign ax_ready_o = (state_q == BURST_IDLE) | (beat_hs & beat_last_o);
  assign ax_hs      = ax_valid_i & ax_ready_o;
  assign busy_o     = (state_q == BURST_ACTIVE);

  always_comb begin
    bytes_in = AddrWidth'(beat_bytes(ax_size_i));
    cmd_err  = (ax_burst_i == 2'b11)
             || (ax_size_i > SizeWidth'(MaxSize))
             || ((ax_burst_i == BURST_WRAP)
                 && (!(ax_len_i inside {8'd1, 8'd3, 8'd7, 8'd15})
                     || ((ax_addr_i & (bytes_in - AddrWidth'(1))) != '0)));
`ifdef AXI_BURST_4K_CHECK_EN
    last_byte = (ax_addr_i & ~(bytes_in - AddrWidth'(1)))
              + (AddrWidth'(ax_len_i) + AddrWidth'(1)) * bytes_in - AddrWidth'(1);
    if ((ax_burst_i == BURST_INCR) && (last_byte[AddrWidth-1:12] != ax_addr_i[AddrWidth-1:12]))
      cmd_err = 1'b1;
`endif
  end

  axi_burst_next_addr #(
    .AddrWidth(AddrWidth),
    .MaxSize  (MaxSize)
  ) u_next_addr (
    .cur_addr_i (beat_addr_o),
    .burst_i    (burst_q),
    .size_i     (size_q),
    .len_i      (len_q),
    .err_i      (beat_err_o),
    .next_addr_o(next_addr)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= BURST_IDLE;
      burst_q      <= BURST_FIXED;
      size_q       <= '0;
      len_q        <= '0;
      beat_valid_o <= 1'b0;
      beat_id_o    <= '0;
      beat_addr_o  <= '0;
      beat_idx_o   <= '0;
      beat_last_o  <= 1'b0;
      beat_err_o   <= 1'b0;
    end else if (ax_hs) begin
      // A new command also covers the last-beat handshake of the previous one
      state_q      <= BURST_ACTIVE;
      burst_q      <= ax_burst_i;
      size_q       <= ax_size_i;
      len_q        <= ax_len_i;
      beat_valid_o <= 1'b1;
      beat_id_o    <= ax_id_i;
      beat_addr_o  <= ax_addr_i;
      beat_idx_o   <= '0;
      beat_last_o  <= (ax_len_i == '0);
      beat_err_o   <= cmd_err;
    end else if (beat_hs) begin
      if (beat_last_o) begin
        state_q      <= BURST_IDLE;
        beat_valid_o <= 1'b0;
        beat_last_o  <= 1'b0;
      end else begin
        beat_addr_o <= next_addr;
        beat_idx_o  <= beat_idx_o + LenWidth'(1);
        beat_last_o <= ((beat_idx_o + LenWidth'(1)) == len_q);
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Scoreboard bench for axi_burst_addr_gen; expected beats come from a spec-level model.
module tb_axi_burst_addr_gen;
  import axi_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned MAXS = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ax_valid;
  logic          ax_ready;
  logic [IW-1:0] ax_id;
  logic [AW-1:0] ax_addr;
  logic [7:0]    ax_len;
  logic [2:0]    ax_size;
  logic [1:0]    ax_burst;
  logic          beat_valid;
  logic          beat_ready;
  logic [IW-1:0] beat_id;
  logic [AW-1:0] beat_addr;
  logic [7:0]    beat_idx;
  logic          beat_last;
  logic          beat_err;
  logic          busy;

  axi_burst_addr_gen #(
    .AddrWidth(AW),
    .IdWidth  (IW),
    .DataWidth(DW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ax_valid_i  (ax_valid),
    .ax_ready_o  (ax_ready),
    .ax_id_i     (ax_id),
    .ax_addr_i   (ax_addr),
    .ax_len_i    (ax_len),
    .ax_size_i   (ax_size),
    .ax_burst_i  (ax_burst),
    .beat_valid_o(beat_valid),
    .beat_ready_i(beat_ready),
    .beat_id_o   (beat_id),
    .beat_addr_o (beat_addr),
    .beat_idx_o  (beat_idx),
    .beat_last_o (beat_last),
    .beat_err_o  (beat_err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    idx;
    logic          last;
    logic          err;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b1;

  function automatic void push_cmd(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                   input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic          err;
    logic [2:0]    sz;
    logic [AW-1:0] bytes, total, lower, aligned, cur, lastb;
    beat_t         b;
    err = (burst == 2'b11) || (size > 3'(MAXS));
    if (burst == 2'b10) begin
      if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) err = 1'b1;
      if ((addr % (AW'(1) << size)) != 0) err = 1'b1;
    end
    sz = (size > 3'(MAXS)) ? 3'(MAXS) : size;
    bytes   = AW'(1) << sz;
    total   = bytes * (AW'(len) + 1);
    lower   = (addr / total) * total;
    aligned = (addr / bytes) * bytes;
`ifdef AXI_BURST_4K_CHECK_EN
    lastb = aligned + (AW'(len) + 1) * bytes - 1;
    if (burst == 2'b01 && (lastb / 4096) != (addr / 4096)) err = 1'b1;
`else
    lastb = '0;
`endif
    cur = addr;
    for (int i = 0; i <= int'(len); i++) begin
      b.id = id; b.idx = 8'(i); b.last = (i == int'(len)); b.err = err;
      if (err || burst == 2'b01) b.addr = (i == 0) ? addr : aligned + AW'(i) * bytes;
      else if (burst == 2'b00) b.addr = addr;
      else begin
        b.addr = cur;
        cur = cur + bytes;
        if (cur == lower + total) cur = lower;
      end
      exp_q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en && rst_n && beat_valid && beat_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected: got id=%0h addr=%h idx=%0d last=%0b err=%0b, required none",
                 beat_id, beat_addr, beat_idx, beat_last, beat_err);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if ({beat_id, beat_addr, beat_idx, beat_last, beat_err} !== e) begin
          failures++;
          $display("FAIL beat: got id=%0h addr=%h idx=%0d last=%0b err=%0b, required id=%0h addr=%h idx=%0d last=%0b err=%0b",
                   beat_id, beat_addr, beat_idx, beat_last, beat_err,
                   e.id, e.addr, e.idx, e.last, e.err);
        end
      end
    end
  end

  task automatic send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input bit model);
    bit ok = 1'b0;
    if (model) push_cmd(id, addr, len, size, burst);
    @(posedge clk) #1;
    ax_valid = 1'b1; ax_id = id; ax_addr = addr; ax_len = len; ax_size = size; ax_burst = burst;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ax_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk) #1;
    ax_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL ax_accept: got ax_ready=0 for 100 cycles, required 1");
    end
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !beat_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: got pending=%0d busy=%0b, required pending=0 busy=0",
               name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ax_ready, busy, beat_valid, beat_last, beat_err, beat_id, beat_addr, beat_idx} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {IW{1'b0}}, {AW{1'b0}}, 8'd0}) begin
      failures++;
      $display("FAIL reset_state: got rdy=%0b busy=%0b v=%0b last=%0b err=%0b id=%0h addr=%h idx=%0d, required rdy=1 rest 0",
               ax_ready, busy, beat_valid, beat_last, beat_err, beat_id, beat_addr, beat_idx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_incr_wrap();
    send(4'h1, 32'h0000_1003, 8'd3, 3'd2, 2'b01, 1'b1);
    drain("incr");
    send(4'h2, 32'h0000_0038, 8'd3, 3'd3, 2'b10, 1'b1);
    drain("wrap");
    send(4'h3, 32'h0000_0100, 8'd7, 3'd1, 2'b10, 1'b1);
    drain("wrap8");
  endtask

  task automatic test_fixed_stall();
    logic [AW+10:0] snap;
    send(4'h4, 32'h0000_0040, 8'd2, 3'd2, 2'b00, 1'b1);
    @(posedge clk) #1;
    beat_ready = 1'b0;
    @(negedge clk);
    snap = {beat_valid, beat_last, beat_addr, beat_idx};
    checks++;
    if (beat_valid !== 1'b1 || beat_idx !== 8'd1) begin
      failures++;
      $display("FAIL stall_beat: got valid=%0b idx=%0d, required valid=1 idx=1", beat_valid, beat_idx);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({beat_valid, beat_last, beat_addr, beat_idx} !== snap) begin
        failures++;
        $display("FAIL stall_hold: got %h, required %h",
                 {beat_valid, beat_last, beat_addr, beat_idx}, snap);
      end
    end
    beat_ready = 1'b1;
    drain("fixed");
  endtask

  task automatic test_back_to_back();
    push_cmd(4'h5, 32'h0000_2000, 8'd0, 3'd2, 2'b01);
    push_cmd(4'h6, 32'h0000_3004, 8'd0, 3'd2, 2'b01);
    @(posedge clk) #1;
    ax_valid = 1'b1; ax_id = 4'h5; ax_addr = 32'h0000_2000; ax_len = 8'd0; ax_size = 3'd2; ax_burst = 2'b01;
    @(posedge clk) #1;
    ax_id = 4'h6; ax_addr = 32'h0000_3004;
    @(negedge clk);
    checks++;
    if (ax_ready !== 1'b1 || beat_last !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready: got ax_ready=%0b last=%0b, required 1 1", ax_ready, beat_last);
    end
    @(posedge clk) #1;
    ax_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (beat_valid !== 1'b1 || beat_addr !== 32'h0000_3004) begin
      failures++;
      $display("FAIL b2b_no_bubble: got valid=%0b addr=%h, required 1 00003004", beat_valid, beat_addr);
    end
    drain("b2b");
  endtask

  task automatic test_errors();
    send(4'h7, 32'h0000_0203, 8'd2, 3'd1, 2'b11, 1'b1);
    drain("reserved");
    send(4'h8, 32'h0000_0100, 8'd2, 3'd2, 2'b10, 1'b1);
    drain("wrap_len");
    send(4'h9, 32'h0000_0104, 8'd3, 3'd3, 2'b10, 1'b1);
    drain("wrap_unaligned");
    send(4'hA, 32'h0000_0010, 8'd1, 3'd5, 2'b01, 1'b1);
    drain("size_clamp");
    send(4'hB, 32'h0000_0FF8, 8'd1, 3'd3, 2'b01, 1'b1);
    drain("page_cross");
    send(4'hC, 32'h0000_0FF0, 8'd1, 3'd3, 2'b01, 1'b1);
    drain("page_fit");
    send(4'hD, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b00, 1'b1);
    drain("fixed_top");
  endtask

  task automatic test_mid_reset();
    bit hit = 1'b0;
    mon_en = 1'b0;
    send(4'hE, 32'h0000_0500, 8'd7, 3'd2, 2'b01, 1'b0);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (beat_valid && beat_idx == 8'd2) begin hit = 1'b1; break; end
    end
    rst_n = 1'b0;
    @(posedge clk) #1;
    checks++;
    if (!hit || beat_valid !== 1'b0 || ax_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got hit=%0b valid=%0b ax_ready=%0b busy=%0b, required 1 0 1 0",
               hit, beat_valid, ax_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (beat_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_quiet: got valid=%0b, required 0", beat_valid);
    end
    mon_en = 1'b1;
  endtask

  initial begin
    ax_valid = 1'b0; ax_id = '0; ax_addr = '0; ax_len = '0; ax_size = '0; ax_burst = '0;
    beat_ready = 1'b1;
    test_reset();
    test_incr_wrap();
    test_fixed_stall();
    test_back_to_back();
    test_errors();
    test_mid_reset();
    send(4'hF, 32'h0000_0800, 8'd1, 3'd2, 2'b01, 1'b1);
    drain("after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
